// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the riscv_mem_responder slice.
// The per-port FSM state encoding, the read-back value for out-of-range accesses and the timer register offsets.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } port_state_t;

    localparam logic [31:0] OOR_READ_VALUE  = 32'h0000_0000;
    localparam logic [31:0] MTIME_OFFSET    = 32'd0;
    localparam logic [31:0] MTIMECMP_OFFSET = 32'd4;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/riscv_mem_port_fsm.sv
// Wait-state handshake for one slave port: IDLE -> WAIT (WAIT_STATES cycles) -> ACK -> IDLE.
// commit is high in the cycle whose closing edge enters ACK; waitrequest is registered.
module riscv_mem_port_fsm
    import riscv_mem_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic req,
    output logic commit,
    output logic waitrequest
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    port_state_t state;
    logic [3:0]  cnt;

    // Gated by nreset so a commit can never coincide with an asserted reset.
    assign commit = nreset &&
                    (((state == IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0)));

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            waitrequest <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state       <= ACK;
                            waitrequest <= 1'b0;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= ACK;
                        waitrequest <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-mapped slave serving a data port and an instruction port from one shared word array.
// Define RISCV_MEM_TIMER_EN to add the mtime/mtimecmp timer and its irq on the data port.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          MEM_ADDR_BITS = 12,
    parameter int          WAIT_STATES   = 1,
    parameter logic [31:0] TIMER_ADDR    = 32'hAFFF_FFE0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] daddress,
    input  logic        dwrite,
    input  logic [31:0] dwritedata,
    input  logic [3:0]  dbyteenable,
    input  logic        dread,
    output logic [31:0] dreaddata,
    output logic        dwaitrequest,
    input  logic [31:0] iaddress,
    input  logic        iread,
    output logic [31:0] ireaddata,
    output logic        iwaitrequest,
    output logic        irq,
    output logic        oor_flag
);

    localparam int HI = MEM_ADDR_BITS + 2;

    logic [31:0]              mem [0:(1 << MEM_ADDR_BITS) - 1];
    logic                     d_commit, i_commit;
    logic                     d_in_range, i_in_range;
    logic [MEM_ADDR_BITS-1:0] d_idx, i_idx;
    logic                     d_hit_timer;
    logic [31:0]              timer_rdata;
    logic                     mem_we;
    logic                     unused_addr_bits;

    riscv_mem_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_dport (
        .clk         (clk),
        .nreset      (nreset),
        .req         (dread | dwrite),
        .commit      (d_commit),
        .waitrequest (dwaitrequest)
    );

    riscv_mem_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_iport (
        .clk         (clk),
        .nreset      (nreset),
        .req         (iread),
        .commit      (i_commit),
        .waitrequest (iwaitrequest)
    );

    assign d_in_range       = (daddress[31:HI] == BASE_ADDR[31:HI]);
    assign i_in_range       = (iaddress[31:HI] == BASE_ADDR[31:HI]);
    assign d_idx            = daddress[HI-1:2];
    assign i_idx            = iaddress[HI-1:2];
    assign mem_we           = d_commit && dwrite && d_in_range && !d_hit_timer;
    assign unused_addr_bits = ^{daddress[1:0], iaddress[1:0]};

    // NOTE: the array is deliberately left out of reset; only the handshake
    // and output registers are reset, which keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dbyteenable[b]) mem[d_idx][8*b +: 8] <= dwritedata[8*b +: 8];
            end
        end
    end

    // Both ports read the pre-edge array contents, so an instruction fetch
    // colliding with a data write to the same word returns the old data.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dreaddata <= 32'h0;
            ireaddata <= 32'h0;
            oor_flag  <= 1'b0;
        end else begin
            if (d_commit) begin
                if (dread && !dwrite) begin
                    if (d_hit_timer)     dreaddata <= timer_rdata;
                    else if (d_in_range) dreaddata <= mem[d_idx];
                    else                 dreaddata <= OOR_READ_VALUE;
                end
                if ((!d_in_range && !d_hit_timer) || (dread && dwrite)) oor_flag <= 1'b1;
            end
            if (i_commit) begin
                ireaddata <= i_in_range ? mem[i_idx] : OOR_READ_VALUE;
                if (!i_in_range) oor_flag <= 1'b1;
            end
        end
    end

`ifdef RISCV_MEM_TIMER_EN
    localparam logic [31:0] MTIME_ADDR    = TIMER_ADDR + MTIME_OFFSET;
    localparam logic [31:0] MTIMECMP_ADDR = TIMER_ADDR + MTIMECMP_OFFSET;

    logic [31:0] mtime, mtimecmp;
    logic        hit_mtime, hit_mtimecmp;

    assign hit_mtime    = (daddress[31:2] == MTIME_ADDR[31:2]);
    assign hit_mtimecmp = (daddress[31:2] == MTIMECMP_ADDR[31:2]);
    assign d_hit_timer  = hit_mtime || hit_mtimecmp;
    assign timer_rdata  = hit_mtime ? mtime : mtimecmp;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mtime    <= 32'h0;
            mtimecmp <= 32'hFFFF_FFFF;
            irq      <= 1'b0;
        end else begin
            irq <= (mtime >= mtimecmp);
            if (d_commit && dwrite && hit_mtime) mtime <= merge_bytes(mtime, dwritedata, dbyteenable);
            else                                 mtime <= mtime + 32'd1;
            if (d_commit && dwrite && hit_mtimecmp)
                mtimecmp <= merge_bytes(mtimecmp, dwritedata, dbyteenable);
        end
    end
`else
    logic unused_timer_addr;

    assign d_hit_timer       = 1'b0;
    assign timer_rdata       = 32'h0;
    assign irq               = 1'b0;
    assign unused_timer_addr = ^TIMER_ADDR;
`endif

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder (WAIT_STATES=2) with an access-level reference model.
// Covers the timer and irq when RISCV_MEM_TIMER_EN is defined.
module tb_riscv_mem_responder;

    localparam int          WS         = 2;
    localparam int          MAB        = 12;
    localparam logic [31:0] TIMER_ADDR = 32'hAFFF_FFE0;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] daddress, dwritedata, dreaddata, iaddress, ireaddata;
    logic [3:0]  dbyteenable;
    logic        dwrite, dread, dwaitrequest, iread, iwaitrequest, irq, oor_flag;

    riscv_mem_responder #(
        .BASE_ADDR     (32'h0),
        .MEM_ADDR_BITS (MAB),
        .WAIT_STATES   (WS),
        .TIMER_ADDR    (TIMER_ADDR)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .daddress     (daddress),
        .dwrite       (dwrite),
        .dwritedata   (dwritedata),
        .dbyteenable  (dbyteenable),
        .dread        (dread),
        .dreaddata    (dreaddata),
        .dwaitrequest (dwaitrequest),
        .iaddress     (iaddress),
        .iread        (iread),
        .ireaddata    (ireaddata),
        .iwaitrequest (iwaitrequest),
        .irq          (irq),
        .oor_flag     (oor_flag)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Expected outputs, maintained by the access-level model below.
    logic        chk_en = 1'b0;
    logic        irq_chk = 1'b1;
    logic        exp_dwait, exp_iwait, exp_oor;
    logic [31:0] exp_dread, exp_iread;
    logic [31:0] mmem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dwaitrequest", {31'h0, dwaitrequest}, {31'h0, exp_dwait});
            check("iwaitrequest", {31'h0, iwaitrequest}, {31'h0, exp_iwait});
            check("dreaddata", dreaddata, exp_dread);
            check("ireaddata", ireaddata, exp_iread);
            check("oor_flag", {31'h0, oor_flag}, {31'h0, exp_oor});
            if (irq_chk) check("irq", {31'h0, irq}, 32'h0);
        end
    end

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'h0000_4000;
    endfunction

    function automatic bit is_timer(input logic [31:0] a);
`ifdef RISCV_MEM_TIMER_EN
        return (a >= TIMER_ADDR) && (a < TIMER_ADDR + 32'd8);
`else
        return (a == 32'h0) && (a != 32'h0);
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        idx = int'(a / 4) % 4096;
        if (!in_range(a)) return 32'h0;
        return mmem.exists(idx) ? mmem[idx] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int          idx;
        logic [31:0] w;
        idx = int'(a / 4) % 4096;
        w   = mmem.exists(idx) ? mmem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w = (w & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
        end
        mmem[idx] = w;
    endtask

    // One access on either or both ports; entered and left just after a rising edge.
    task automatic access(input bit d_en, input bit d_wr, input bit d_rd,
                          input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                          input bit i_en, input logic [31:0] ia);
        logic [31:0] d_exp, i_exp;
        dread       = d_en & d_rd;
        dwrite      = d_en & d_wr;
        daddress    = da;
        dwritedata  = wd;
        dbyteenable = be;
        iread       = i_en;
        iaddress    = ia;
        d_exp       = model_read(da);
        i_exp       = model_read(ia);
        for (int c = 0; c <= WS; c++) begin
            exp_dwait = 1'b1;
            exp_iwait = 1'b1;
            @(posedge clk);
            #1;
        end
        if (d_en) begin
            exp_dwait = 1'b0;
            if (d_rd && !d_wr) exp_dread = d_exp;
            if (d_wr && in_range(da) && !is_timer(da)) model_write(da, wd, be);
            if ((!in_range(da) && !is_timer(da)) || (d_rd && d_wr)) exp_oor = 1'b1;
        end
        if (i_en) begin
            exp_iwait = 1'b0;
            exp_iread = i_exp;
            if (!in_range(ia)) exp_oor = 1'b1;
        end
        dread  = 1'b0;
        dwrite = 1'b0;
        iread  = 1'b0;
        @(posedge clk);
        #1;
        exp_dwait = 1'b1;
        exp_iwait = 1'b1;
    endtask

    task automatic dwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        access(1'b1, 1'b1, 1'b0, a, d, be, 1'b0, 32'h0);
    endtask

    task automatic drd(input logic [31:0] a);
        access(1'b1, 1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic ird(input logic [31:0] a);
        access(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dwait", {31'h0, dwaitrequest}, 32'h1);
        check("rst_iwait", {31'h0, iwaitrequest}, 32'h1);
        check("rst_dreaddata", dreaddata, 32'h0);
        check("rst_oor", {31'h0, oor_flag}, 32'h0);
        nreset    = 1'b1;
        exp_dwait = 1'b1;
        exp_iwait = 1'b1;
        exp_dread = 32'h0;
        exp_iread = 32'h0;
        exp_oor   = 1'b0;
        chk_en    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        {dwrite, dread, iread} = 3'b000;
        daddress = 32'h0; dwritedata = 32'h0; dbyteenable = 4'h0; iaddress = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        dwr(32'h100, 32'h1234_5678, 4'hF);
        drd(32'h100);
        check("rd_full_word", dreaddata, 32'h1234_5678);
        dwr(32'h100, 32'hAABB_CCDD, 4'h2);
        drd(32'h100);
        check("rd_lane1_merge", dreaddata, 32'h1234_CC78);
        ird(32'h100);
        check("ird_lane1_merge", ireaddata, 32'h1234_CC78);
        drd(32'h103);
        check("rd_low_bits_ignored", dreaddata, 32'h1234_CC78);

        dwr(32'h104, 32'h0000_0055, 4'hF);
        dwr(32'h200, 32'hCAFE_F00D, 4'hF);
        access(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b1, 32'h104);
        check("same_edge_old_data", ireaddata, 32'h0000_0055);
        drd(32'h104);
        check("same_edge_new_data", dreaddata, 32'h0);
        dwr(32'h200, 32'h0, 4'h0);
        drd(32'h200);
        check("be_zero_no_change", dreaddata, 32'hCAFE_F00D);

        // Reset pulsed while a write to 0x200 is in WAIT.
        dwrite = 1'b1; daddress = 32'h200; dwritedata = 32'h0BAD_0BAD; dbyteenable = 4'hF;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        nreset = 1'b0;
        #1;
        check("rst_mid_dwait", {31'h0, dwaitrequest}, 32'h1);
        dwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        exp_dread = 32'h0; exp_iread = 32'h0; exp_oor = 1'b0; exp_dwait = 1'b1; exp_iwait = 1'b1;
        chk_en = 1'b1;
        drd(32'h200);
        check("rst_mid_write_dropped", dreaddata, 32'hCAFE_F00D);

        dwr(32'h0, 32'h1111_1111, 4'hF);
        drd(32'h0001_0000);
        check("oor_read_zero", dreaddata, 32'h0);
        check("oor_flag_set", {31'h0, oor_flag}, 32'h1);
        dwr(32'h0001_0000, 32'hFFFF_FFFF, 4'hF);
        drd(32'h0);
        check("oor_write_dropped", dreaddata, 32'h1111_1111);
        ird(32'h0002_0000);
        check("oor_iread_zero", ireaddata, 32'h0);

        do_reset();
        access(1'b1, 1'b1, 1'b1, 32'h300, 32'h77, 4'hF, 1'b0, 32'h0);
        check("collision_oor", {31'h0, oor_flag}, 32'h1);
        drd(32'h300);
        check("collision_is_write", dreaddata, 32'h77);

`ifdef RISCV_MEM_TIMER_EN
        irq_chk = 1'b0;
        dwr(TIMER_ADDR + 32'd4, 32'd10, 4'hF);
        dwr(TIMER_ADDR, 32'd0, 4'hF);
        // mtime equals k in the k-th cycle after the ACK of the mtime write.
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("irq_vs_mtime", {31'h0, irq}, (k >= 11) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
        end
        dwr(TIMER_ADDR + 32'd4, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        irq_chk = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
